// File: rtl/rom_read_ctl_pkg.sv
// rtl/rom_read_ctl_pkg.sv - shared types and constants for the ROM read controller
// Purpose : bus widths, controller state encoding and an address-increment helper.
// Optional: ROM_PREFETCH_EN adds the PREFETCH state.
package rom_read_ctl_pkg;

  localparam int ROM_AW = 13;
  localparam int ROM_DW = 16;

`ifdef ROM_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WAIT, ACK, PREFETCH} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WAIT, ACK} state_t;
`endif

  // Next word address; wraps from the top of the ROM window back to 0.
  function automatic logic [ROM_AW-1:0] next_addr(input logic [ROM_AW-1:0] a);
    return a + {{(ROM_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rom_read_ctl_if.sv
// rtl/rom_read_ctl_if.sv - CPU-side and ROM-side bus bundle for the ROM read controller
// Purpose : groups the 68000 bus cycle signals and the synchronous ROM port.
// Ports   : cpu_a, cpu_as_n, cpu_rw, rom_sel, cpu_d, cpu_dtack_n (CPU side);
//           rom_a, rom_ce_n, rom_oe_n, rom_d (ROM side).
// Modports: master = controller, slave = CPU decode plus ROM.
interface rom_read_ctl_if;
  import rom_read_ctl_pkg::*;

  logic [ROM_AW-1:0] cpu_a;
  logic              cpu_as_n;
  logic              cpu_rw;
  logic              rom_sel;
  logic [ROM_DW-1:0] cpu_d;
  logic              cpu_dtack_n;
  logic [ROM_AW-1:0] rom_a;
  logic              rom_ce_n;
  logic              rom_oe_n;
  logic [ROM_DW-1:0] rom_d;

  modport master (
    input  cpu_a, cpu_as_n, cpu_rw, rom_sel, rom_d,
    output cpu_d, cpu_dtack_n, rom_a, rom_ce_n, rom_oe_n
  );

  modport slave (
    output cpu_a, cpu_as_n, cpu_rw, rom_sel, rom_d,
    input  cpu_d, cpu_dtack_n, rom_a, rom_ce_n, rom_oe_n
  );

endinterface

// File: rtl/rom_read_ctl_prefetch_buf.sv
// rtl/rom_read_ctl_prefetch_buf.sv - one-word prefetch buffer with address tag
// Purpose : holds one speculatively read ROM word, its address tag and a valid bit.
// Ports   : clk, reset (sync active-high), clr (drop valid), load/load_a/load_d (fill),
//           look_a (lookup address), hit (valid and tag match), data (buffered word).
// Used only when ROM_PREFETCH_EN is defined.
module rom_prefetch_buf
  import rom_read_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [ROM_AW-1:0] load_a,
  input  logic [ROM_DW-1:0] load_d,
  input  logic [ROM_AW-1:0] look_a,
  output logic              hit,
  output logic [ROM_DW-1:0] data
);

  logic              valid;
  logic [ROM_AW-1:0] tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_a;
      data  <= load_d;
    end
  end

  assign hit = valid && (tag == look_a);

endmodule

// File: rtl/rom_read_ctl.sv
// rtl/rom_read_ctl.sv - converts a 68000 async bus read into a synchronous ROM access
// Purpose : registers the CPU request, pulses rom_ce_n/rom_oe_n for one cycle, captures
//           the ROM word and terminates the cycle with DTACK after WAIT_STATES cycles.
// Ports   : clk, reset (sync active-high), bus (rom_read_ctl_if.master).
// Params  : WAIT_STATES (0-15) extra cycles between data capture and DTACK.
// Optional: ROM_PREFETCH_EN reads the next word while idle into rom_prefetch_buf.
module rom_read_ctl
  import rom_read_ctl_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  rom_read_ctl_if.master bus
);

  // Entering WAIT loads WAIT_STATES-1; unused when WAIT_STATES is 0.
  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES - 1);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);

  state_t            state, next_state, done_state;
  logic              req_as_n, req_rw, req_sel;
  logic [ROM_AW-1:0] req_a;
  logic [3:0]        wait_cnt;
  logic [ROM_DW-1:0] cpu_d_q;
  logic [ROM_AW-1:0] rom_a_q;
  logic              dtack_n_q, ce_n_q, oe_n_q;
  logic              req_valid, abort, hit, accept, accept_rd;

  // The request is taken from the registered bus inputs, so no CPU input reaches an
  // output combinationally; the strobe release is seen directly to end cycles promptly.
  assign req_valid  = !req_as_n && req_sel;
  assign abort      = bus.cpu_as_n;
  assign done_state = HAS_WAIT ? WAIT : ACK;
  assign accept_rd  = accept && req_rw;

`ifdef ROM_PREFETCH_EN
  logic              pf_arm, pf_phase, from_buf, accept_hit;
  logic [ROM_DW-1:0] buf_data;

  rom_prefetch_buf u_buf (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept && !req_rw),
    .load   (state == PREFETCH && pf_phase),
    .load_a (rom_a_q),
    .load_d (bus.rom_d),
    .look_a (req_a),
    .hit    (hit),
    .data   (buf_data)
  );

  assign accept_hit = accept_rd && hit;
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) accept = 1'b1;
`ifdef ROM_PREFETCH_EN
        else if (pf_arm) next_state = PREFETCH;
`endif
      end
      ISSUE:   next_state = abort ? IDLE : CAPTURE;
      CAPTURE: next_state = abort ? IDLE : done_state;
      WAIT: begin
        if (abort) next_state = IDLE;
        else if (wait_cnt == 4'd0) next_state = ACK;
      end
      ACK: if (abort) next_state = IDLE;
`ifdef ROM_PREFETCH_EN
      // A read of the word being prefetched waits for it and is served from the buffer
      // back in IDLE; anything else abandons the prefetch.
      PREFETCH: begin
        if (req_valid && !(req_rw && req_a == rom_a_q)) accept = 1'b1;
        else if (pf_phase) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
    if (accept) begin
      if (!req_rw)  next_state = ACK;
      else if (hit) next_state = done_state;
      else          next_state = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_as_n  <= 1'b1;
      req_rw    <= 1'b1;
      req_sel   <= 1'b0;
      req_a     <= '0;
      wait_cnt  <= '0;
      cpu_d_q   <= '0;
      rom_a_q   <= '0;
      dtack_n_q <= 1'b1;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
`ifdef ROM_PREFETCH_EN
      pf_arm    <= 1'b0;
      pf_phase  <= 1'b0;
      from_buf  <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      req_as_n  <= bus.cpu_as_n;
      req_rw    <= bus.cpu_rw;
      req_sel   <= bus.rom_sel;
      req_a     <= bus.cpu_a;
      ce_n_q    <= (next_state != ISSUE);
      oe_n_q    <= (next_state != ISSUE);
      dtack_n_q <= (next_state != ACK);
      if (accept_rd) rom_a_q <= req_a;
      // An abort out of CAPTURE leaves cpu_d untouched.
      if (state == CAPTURE && next_state != IDLE) cpu_d_q <= bus.rom_d;
      if (next_state == WAIT && state != WAIT) wait_cnt <= WS_LOAD;
      else if (next_state == WAIT)              wait_cnt <= wait_cnt - 4'd1;
      else                                      wait_cnt <= '0;
`ifdef ROM_PREFETCH_EN
      if (state != PREFETCH && next_state == PREFETCH) begin
        rom_a_q <= next_addr(rom_a_q);
        ce_n_q  <= 1'b0;
        oe_n_q  <= 1'b0;
      end
      pf_phase <= (state == PREFETCH) && (next_state == PREFETCH);
      if (state == ACK && next_state == IDLE && req_rw) pf_arm <= 1'b1;
      else if (state == IDLE && next_state != IDLE)     pf_arm <= 1'b0;
      if (accept) from_buf <= accept_hit;
      if ((accept_hit && next_state == ACK) ||
          (state == WAIT && next_state == ACK && from_buf))
        cpu_d_q <= buf_data;
`endif
    end
  end

  assign bus.cpu_d       = cpu_d_q;
  assign bus.cpu_dtack_n = dtack_n_q;
  assign bus.rom_a       = rom_a_q;
  assign bus.rom_ce_n    = ce_n_q;
  assign bus.rom_oe_n    = oe_n_q;

endmodule

// File: doc/rom_read_ctl.md
# rom_read_ctl

CPU-side bus initiator for the 16-bit program ROMs. Converts the 68000-style asynchronous bus cycle (AS/RW/DTACK) into single-cycle requests on the ROM's synchronous port, where an active-low enable is sampled on a clock edge and data is registered one cycle later. It captures the ROM word, presents it to the CPU and terminates the cycle with DTACK. It sits between the CPU address decode and each ROM pair instance.

## Interface
- WAIT_STATES, 0: extra cycles inserted between data capture and DTACK assertion (0–15).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_a  in  13  CPU word address within the ROM window.
- cpu_as_n  in  1  address strobe, active low.
- cpu_rw  in  1  1 = read, 0 = write.
- rom_sel  in  1  address decode hit for this ROM.
- cpu_d  out  16  read data to the CPU.
- cpu_dtack_n  out  1  data acknowledge, active low.
- rom_a  out  13  ROM word address.
- rom_ce_n  out  1  ROM enable, active low. The ROM samples it on the clock edge.
- rom_oe_n  out  1  ROM output enable, active low.
- rom_d  in  16  ROM data, valid the cycle after the edge that samples rom_ce_n = 0.

## Operation
- Reset values: cpu_d = 0, cpu_dtack_n = 1, rom_a = 0, rom_ce_n = 1, rom_oe_n = 1, state IDLE, wait counter 0.
- States: IDLE, ISSUE, CAPTURE, WAIT, ACK.
- IDLE → ISSUE when cpu_as_n = 0, rom_sel = 1 and cpu_rw = 1. On that transition, rom_a ← cpu_a.
- ISSUE drives rom_ce_n = 0 and rom_oe_n = 0 for exactly one cycle, then goes to CAPTURE.
- CAPTURE latches cpu_d ← rom_d. It goes to WAIT if WAIT_STATES > 0, otherwise to ACK.
- WAIT counts down WAIT_STATES cycles, then goes to ACK.
- ACK holds cpu_dtack_n = 0 and cpu_d stable until cpu_as_n = 1, then returns to IDLE with cpu_dtack_n = 1.
- Write to the ROM window (cpu_rw = 0, rom_sel = 1): no ROM access, cpu_d unchanged, go straight to ACK so the CPU does not hang.
- Abort: if cpu_as_n rises in ISSUE, CAPTURE or WAIT, return to IDLE. cpu_dtack_n stays 1 and cpu_d is unchanged.
- Back-to-back cycles: a new request is only recognised in IDLE. cpu_as_n must be observed high at least one edge between cycles.
- Reset mid-cycle: the reset values above apply at the next edge.

## Timing
- The request is sampled at edge n.
- rom_ce_n is low during cycle n+1 and sampled by the ROM at edge n+2.
- cpu_d is valid after edge n+3.
- cpu_dtack_n is low after edge n+3+WAIT_STATES.
- cpu_dtack_n is released at the first edge that samples cpu_as_n = 1.
- All outputs are registered. There is no combinational path from CPU inputs to outputs.

## Configuration
- ROM_PREFETCH_EN defined:
  - After each completed read at address A, the controller issues a read at A+1 while in IDLE. The address wraps 8191 → 0.
  - The result goes into a one-word buffer with an address tag and a valid bit.
  - A read that hits the tag gets cpu_d from the buffer, and cpu_dtack_n goes low after edge n+1+WAIT_STATES.
  - A request that arrives while the prefetch is in flight:
    - if it matches the prefetch address, it waits for the capture and is then served as a hit;
    - otherwise the prefetch is abandoned and the request is issued at the next edge.
  - A write to the window or reset clears the valid bit.
- ROM_PREFETCH_EN undefined: no buffer and no speculative rom_ce_n activity. rom_ce_n is low only during ISSUE.

## Structure
- Shared package: state enum (IDLE, ISSUE, CAPTURE, WAIT, ACK, plus PREFETCH under the macro), ROM_AW = 13, ROM_DW = 16.
- One sub-module, rom_prefetch_buf: tag, valid bit, data register and hit compare. It is instantiated only under ROM_PREFETCH_EN.

## Test plan
- Read at 0x0123 with the ROM model holding 0xBEEF, WAIT_STATES = 0: cpu_d = 0xBEEF, and cpu_dtack_n falls 3 edges after the request.
- Same read with WAIT_STATES = 2: cpu_dtack_n falls 5 edges after the request. It stays low until cpu_as_n rises, then goes high at the next edge.
- Write to 0x0040: rom_ce_n never goes low, cpu_dtack_n falls, cpu_d is unchanged.
- cpu_as_n rises during CAPTURE: cpu_dtack_n stays 1, and the next read at 0x0001 completes normally.
- Reset asserted in WAIT: all outputs return to reset values at the next edge.
- With ROM_PREFETCH_EN:
  - read 0x1FFF, then read 0x0000: the second read hits (wrap), with cpu_dtack_n low after edge n+1;
  - read 0x0010, then read 0x0500: the second read misses with the full latency and correct data.
